// File: rtl/pixel_compositor_pkg.sv
// Shared definitions for the pixel compositor: width helpers and a set of
// default palette colours the host logic can load after reset.
package compositor_pkg;

  // Ceiling log2 usable in parameter expressions; clog2(1) = 0.
  function automatic int clog2(input int value);
    int v;
    int r;
    v = value - 1;
    r = 0;
    while (v > 0) begin
      r++;
      v = v >> 1;
    end
    return r;
  endfunction

  // Clamp a derived width to at least one bit so degenerate parameter
  // choices (one layer, one blink frame) still give legal vectors.
  function automatic int width1(input int w);
    return (w < 1) ? 1 : w;
  endfunction

  localparam int CW_DEFAULT = 10;
  localparam int RGB_W      = 3 * CW_DEFAULT;

  // Pack three channels into the {R,G,B} palette word layout.
  function automatic logic [RGB_W-1:0] pack_rgb(
    input logic [CW_DEFAULT-1:0] r,
    input logic [CW_DEFAULT-1:0] g,
    input logic [CW_DEFAULT-1:0] b
  );
    return {r, g, b};
  endfunction

  // Default colours, {R,G,B} with 10 bits per channel.
  localparam logic [RGB_W-1:0] COL_BLACK        = {10'h000, 10'h000, 10'h000};
  localparam logic [RGB_W-1:0] COL_WHITE        = {10'h3FF, 10'h3FF, 10'h3FF};
  localparam logic [RGB_W-1:0] COL_BRICK_RED    = {10'h3FF, 10'h040, 10'h040};
  localparam logic [RGB_W-1:0] COL_BRICK_ORANGE = {10'h3FF, 10'h200, 10'h000};
  localparam logic [RGB_W-1:0] COL_BRICK_YELLOW = {10'h3FF, 10'h3FF, 10'h000};
  localparam logic [RGB_W-1:0] COL_BRICK_GREEN  = {10'h000, 10'h300, 10'h080};
  localparam logic [RGB_W-1:0] COL_BRICK_BLUE   = {10'h080, 10'h100, 10'h3FF};
  localparam logic [RGB_W-1:0] COL_GW_BLUE      = {10'h000, 10'h155, 10'h206};
  localparam logic [RGB_W-1:0] COL_GW_GOLD      = {10'h3A0, 10'h2C0, 10'h0A0};

endpackage

// File: rtl/pixel_compositor_if.sv
// Pixel, control and palette-write signals between the object generators
// (master side) and the compositor (slave side). Names keep the i/o sense
// as seen from the compositor.
interface pixel_compositor_if
  import compositor_pkg::*;
#(
  parameter int N_LAYERS  = 8,
  parameter int CW        = 10,
  parameter int PAL_DEPTH = 16
);
  localparam int IW = width1(clog2(PAL_DEPTH));
  localparam int LW = width1(clog2(N_LAYERS));

  // Pixel stream and per-layer coverage
  logic                   iPix_Valid;
  logic [N_LAYERS-1:0]    iLayer_Hit;
  logic [N_LAYERS*IW-1:0] iLayer_Idx;
  logic [N_LAYERS-1:0]    iBlink_Mask;
  logic [IW-1:0]          iBg_Idx;
  logic                   iFrame_Start;
  logic                   iEnable;

  // Palette write port
  logic                   iPal_We;
  logic [IW-1:0]          iPal_Addr;
  logic [3*CW-1:0]        iPal_Data;

  // Composited output
  logic [CW-1:0]          oVGA_R;
  logic [CW-1:0]          oVGA_G;
  logic [CW-1:0]          oVGA_B;
  logic                   oPix_Valid;
  logic                   oHit_Any;
  logic [LW-1:0]          oHit_Layer;

  modport master (
    output iPix_Valid, iLayer_Hit, iLayer_Idx, iBlink_Mask, iBg_Idx,
           iFrame_Start, iEnable, iPal_We, iPal_Addr, iPal_Data,
    input  oVGA_R, oVGA_G, oVGA_B, oPix_Valid, oHit_Any, oHit_Layer
  );

  modport slave (
    input  iPix_Valid, iLayer_Hit, iLayer_Idx, iBlink_Mask, iBg_Idx,
           iFrame_Start, iEnable, iPal_We, iPal_Addr, iPal_Data,
    output oVGA_R, oVGA_G, oVGA_B, oPix_Valid, oHit_Any, oHit_Layer
  );

endinterface

// File: rtl/pixel_compositor_prio_enc.sv
// Fixed-priority encoder over the layer hit flags; layer 0 is on top.
module layer_prio_enc
  import compositor_pkg::*;
#(
  parameter int N = 8,
  localparam int IDX_W = width1(clog2(N))
) (
  input  logic [N-1:0]     hit,
  output logic             any,
  output logic [IDX_W-1:0] idx
);

  // Scan from the lowest-priority layer upward so the lowest index set wins.
  always_comb begin
    any = 1'b0;
    idx = '0;
    for (int k = N - 1; k >= 0; k--) begin
      if (hit[k]) begin
        any = 1'b1;
        idx = IDX_W'(k);
      end
    end
  end

endmodule

// File: rtl/pixel_compositor.sv
// Two-stage layer compositor: priority resolve + blink masking in stage 1,
// palette lookup and display-enable blanking in stage 2.
module pixel_compositor
  import compositor_pkg::*;
#(
  parameter int N_LAYERS     = 8,
  parameter int CW           = 10,
  parameter int PAL_DEPTH    = 16,
  parameter int BLINK_FRAMES = 30,
  localparam int IW = width1(clog2(PAL_DEPTH)),
  localparam int LW = width1(clog2(N_LAYERS))
) (
  input  logic iCLK,
  input  logic iRST_N,
  pixel_compositor_if.slave bus
);

  localparam int              BW       = width1(clog2(BLINK_FRAMES));
  localparam logic [BW-1:0]   CNT_LAST = BW'(BLINK_FRAMES - 1);

  // Blink state
  logic [BW-1:0]      r_blink_cnt;
  logic               r_blink_phase;

  // Stage-0 (combinational) resolve
  logic [N_LAYERS-1:0] w_eff_hit_p0;
  logic                w_any_p0;
  logic [LW-1:0]       w_layer_p0;
  logic [IW-1:0]       w_layer_idx_p0 [N_LAYERS];
  logic [IW-1:0]       w_pal_idx_p0;

  // Stage-1 registers
  logic                r_vld_p1;
  logic                r_en_p1;
  logic                r_any_p1;
  logic [LW-1:0]       r_layer_p1;
  logic [IW-1:0]       r_pidx_p1;

  // Stage-2 registers
  logic                r_vld_p2;
  logic                r_any_p2;
  logic [LW-1:0]       r_layer_p2;
  logic [3*CW-1:0]     r_rgb_p2;

  // Palette storage
  logic [3*CW-1:0]     r_pal [PAL_DEPTH];

  // Frame counter: wraps after BLINK_FRAMES frame pulses and flips the phase
  // on the wrapping edge. Phase 1 means blinking layers are visible.
  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) begin
      r_blink_cnt   <= '0;
      r_blink_phase <= 1'b1;
    end else if (bus.iFrame_Start) begin
      if (r_blink_cnt == CNT_LAST) begin
        r_blink_cnt   <= '0;
        r_blink_phase <= ~r_blink_phase;
      end else begin
        r_blink_cnt   <= r_blink_cnt + 1'b1;
      end
    end
  end

  // ---- stage 0: blink masking, priority resolve, index select ----
  assign w_eff_hit_p0 = r_blink_phase ? bus.iLayer_Hit
                                      : (bus.iLayer_Hit & ~bus.iBlink_Mask);

  layer_prio_enc #(.N(N_LAYERS)) u_prio (
    .hit (w_eff_hit_p0),
    .any (w_any_p0),
    .idx (w_layer_p0)
  );

  // Unpack the flat per-layer palette index bus into an array.
  always_comb begin
    for (int k = 0; k < N_LAYERS; k++) begin
      w_layer_idx_p0[k] = bus.iLayer_Idx[k*IW +: IW];
    end
  end

  assign w_pal_idx_p0 = w_any_p0 ? w_layer_idx_p0[w_layer_p0] : bus.iBg_Idx;

  // ---- stage 1: register resolved layer, palette index and qualifiers ----
  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) begin
      r_vld_p1   <= 1'b0;
      r_en_p1    <= 1'b0;
      r_any_p1   <= 1'b0;
      r_layer_p1 <= '0;
      r_pidx_p1  <= '0;
    end else begin
      r_vld_p1   <= bus.iPix_Valid;
      r_en_p1    <= bus.iEnable;
      r_any_p1   <= w_any_p0;
      r_layer_p1 <= w_layer_p0;
      r_pidx_p1  <= w_pal_idx_p0;
    end
  end

  // Palette write port; a same-edge stage-2 read sees the previous contents.
  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) begin
      for (int i = 0; i < PAL_DEPTH; i++) begin
        r_pal[i] <= '0;
      end
    end else if (bus.iPal_We) begin
      r_pal[bus.iPal_Addr] <= bus.iPal_Data;
    end
  end

  // ---- stage 2: palette lookup, blank when display disabled ----
  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) begin
      r_vld_p2   <= 1'b0;
      r_any_p2   <= 1'b0;
      r_layer_p2 <= '0;
      r_rgb_p2   <= '0;
    end else begin
      r_vld_p2   <= r_vld_p1;
      r_any_p2   <= r_any_p1;
      r_layer_p2 <= r_layer_p1;
      r_rgb_p2   <= r_en_p1 ? r_pal[r_pidx_p1] : '0;
    end
  end

  assign bus.oVGA_R     = r_rgb_p2[3*CW-1 -: CW];
  assign bus.oVGA_G     = r_rgb_p2[2*CW-1 -: CW];
  assign bus.oVGA_B     = r_rgb_p2[CW-1   -: CW];
  assign bus.oPix_Valid = r_vld_p2;
  assign bus.oHit_Any   = r_any_p2;
  assign bus.oHit_Layer = r_layer_p2;

endmodule
